// File: rtl/count_if.sv
// Bus between a count source and count_checker: the monitored count stream,
// the statistics clear, and the checker's registered results.
interface count_if #(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
);
  // Handshake: count is sampled at a rising clock edge only while count_valid is
  // high; the checker has no back-pressure and accepts every valid beat.
  logic                  count_valid;
  logic [WIDTH-1:0]      count;
  logic                  clear;
  logic                  locked;
  logic                  mismatch;
  logic                  sticky_err;
  logic [ERR_CNT_W-1:0]  err_count;
  logic [WRAP_CNT_W-1:0] wrap_count;
  logic [WIDTH-1:0]      expected;
  logic [1:0]            state_dbg;

  modport master (
    output count_valid, count, clear,
    input  locked, mismatch, sticky_err, err_count, wrap_count, expected, state_dbg
  );

  modport slave (
    input  count_valid, count, clear,
    output locked, mismatch, sticky_err, err_count, wrap_count, expected, state_dbg
  );
endinterface

// File: rtl/count_checker.sv
// Sequence monitor for a free-running +1 counter: acquires lock, flags every
// deviation and keeps saturating error / wrap statistics.
module count_checker #(
  parameter int WIDTH       = 4,
  parameter int SYNC_CYCLES = 2,
  parameter int ERR_CNT_W   = 8,
  parameter int WRAP_CNT_W  = 8
) (
  input  logic   clock,
  input  logic   reset,
  count_if.slave bus
);
  localparam int RUN_W = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(SYNC_CYCLES - 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t                state;
  logic [WIDTH-1:0]      prev;
  logic [RUN_W-1:0]      run;
  logic                  locked_q;
  logic                  mismatch_q;
  logic                  sticky_q;
  logic [ERR_CNT_W-1:0]  err_q;
  logic [WRAP_CNT_W-1:0] wrap_q;
  logic [WIDTH-1:0]      expected_q;

  logic                  inc_ok;
  logic [WIDTH-1:0]      count_next;
  logic [ERR_CNT_W-1:0]  err_base;
  logic [WRAP_CNT_W-1:0] wrap_base;

  assign inc_ok     = (bus.count == prev + 1'b1);
  assign count_next = bus.count + 1'b1;
  // Clear happens first, so an event in the same cycle counts from zero.
  assign err_base   = bus.clear ? '0 : err_q;
  assign wrap_base  = bus.clear ? '0 : wrap_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= UNLOCKED;
      prev       <= '0;
      run        <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
      err_q      <= '0;
      wrap_q     <= '0;
      expected_q <= '0;
    end else begin
      mismatch_q <= 1'b0;
      if (bus.clear) begin
        sticky_q <= 1'b0;
        err_q    <= '0;
        wrap_q   <= '0;
      end
      if (bus.count_valid) begin
        prev       <= bus.count;
        expected_q <= count_next;
        case (state)
          UNLOCKED: begin
            run   <= '0;
            state <= ACQUIRE;
          end
          ACQUIRE: begin
            if (!inc_ok) begin
              run <= '0;
            end else if (run == RUN_LAST) begin
              run      <= '0;
              state    <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              run <= run + 1'b1;
            end
          end
          LOCKED: begin
            if (inc_ok) begin
              if (&prev)
                wrap_q <= (&wrap_base) ? wrap_base : wrap_base + 1'b1;
            end else begin
              mismatch_q <= 1'b1;
              sticky_q   <= 1'b1;
              err_q      <= (&err_base) ? err_base : err_base + 1'b1;
              run        <= '0;
              state      <= ACQUIRE;
              locked_q   <= 1'b0;
            end
          end
          default: begin
            run      <= '0;
            state    <= UNLOCKED;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.sticky_err = sticky_q;
  assign bus.err_count  = err_q;
  assign bus.wrap_count = wrap_q;
  assign bus.expected   = expected_q;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: directed vector table, hand-written reset and
// re-acquire sequences, then random traffic against a reference model.
module tb_count_checker;
  localparam int WIDTH       = 4;
  localparam int SYNC_CYCLES = 2;
  localparam int ERR_CNT_W   = 2;
  localparam int WRAP_CNT_W  = 3;
  localparam int OUT_W       = 3 + ERR_CNT_W + WRAP_CNT_W + WIDTH;
  localparam int MODV        = 1 << WIDTH;
  localparam int ERR_MAX     = (1 << ERR_CNT_W) - 1;
  localparam int WRAP_MAX    = (1 << WRAP_CNT_W) - 1;

  // clock / reset block
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  count_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W), .WRAP_CNT_W(WRAP_CNT_W)) bus ();

  count_checker #(
    .WIDTH(WIDTH), .SYNC_CYCLES(SYNC_CYCLES),
    .ERR_CNT_W(ERR_CNT_W), .WRAP_CNT_W(WRAP_CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] cnt;
    logic             clr;
    logic             locked;
    logic             mismatch;
    logic             sticky;
    int               err;
    int               wrap;
    int               expd;
  } vec_t;

  vec_t vecs[$];
  logic [OUT_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // reference model, in terms of the behavioural rules
  int m_state;   // 0 unlocked, 1 acquiring, 2 locked
  int m_prev, m_run, m_err, m_wrap;
  bit m_sticky, m_mm;

  function automatic logic [OUT_W-1:0] pack(bit l, bit m, bit s, int e, int w, int x);
    logic [ERR_CNT_W-1:0]  e_v = ERR_CNT_W'(e);
    logic [WRAP_CNT_W-1:0] w_v = WRAP_CNT_W'(w);
    logic [WIDTH-1:0]      x_v = WIDTH'(x);
    return {l, m, s, e_v, w_v, x_v};
  endfunction

  function automatic logic [OUT_W-1:0] dut_word();
    return {bus.locked, bus.mismatch, bus.sticky_err, bus.err_count, bus.wrap_count, bus.expected};
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual={l,m,s,err,wrap,exp}=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit v, input int c, input bit clr, input bit l, input bit m,
                     input bit s, input int e, input int w, input int x);
    vec_t t;
    t.valid = v; t.cnt = WIDTH'(c); t.clr = clr;
    t.locked = l; t.mismatch = m; t.sticky = s; t.err = e; t.wrap = w; t.expd = x % MODV;
    vecs.push_back(t);
  endtask

  // driver: present one beat, let one edge pass, sample 1 ns later
  task automatic drive(input bit v, input logic [WIDTH-1:0] c, input bit clr);
    bus.count_valid = v;
    bus.count       = c;
    bus.clear       = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    bus.count_valid = 1'b1; bus.count = 4'd9; bus.clear = 1'b0;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b1;
    m_state = 0; m_prev = 0; m_run = 0; m_err = 0; m_wrap = 0; m_sticky = 0; m_mm = 0;
  endtask

  task automatic model_step(input bit v, input int c, input bit clr);
    bit inc_ok;
    m_mm = 0;
    if (clr) begin m_sticky = 0; m_err = 0; m_wrap = 0; end
    if (v) begin
      inc_ok = (c == (m_prev + 1) % MODV);
      if (m_state == 0) begin
        m_state = 1; m_run = 0;
      end else if (m_state == 1) begin
        if (inc_ok) begin
          m_run++;
          if (m_run == SYNC_CYCLES) begin m_state = 2; m_run = 0; end
        end else m_run = 0;
      end else begin
        if (inc_ok) begin
          if (m_prev == MODV - 1 && m_wrap < WRAP_MAX) m_wrap++;
        end else begin
          m_mm = 1; m_sticky = 1; m_state = 1; m_run = 0;
          if (m_err < ERR_MAX) m_err++;
        end
      end
      m_prev = c;
    end
  endtask

  function automatic logic [OUT_W-1:0] model_word();
    return pack(m_state == 2, m_mm, m_sticky, m_err, m_wrap,
                (m_state == 0) ? 0 : (m_prev + 1) % MODV);
  endfunction

  initial begin
    bus.count_valid = 1'b0; bus.count = '0; bus.clear = 1'b0;

    // directed table
    add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0, 2);
    add(1, 2, 0, 1, 0, 0, 0, 0, 3);
    add(1, 3, 0, 1, 0, 0, 0, 0, 4);
    for (int c = 4; c < 16; c++) add(1, c, 0, 1, 0, 0, 0, 0, c + 1);
    add(1, 0, 0, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 1, 0, 0, 0, 1, 2);
    for (int c = 2; c <= 5; c++) add(1, c, 0, 1, 0, 0, 0, 1, c + 1);
    add(1, 7, 0, 0, 1, 1, 1, 1, 8);
    add(1, 8, 0, 0, 0, 1, 1, 1, 9);
    add(1, 9, 0, 1, 0, 1, 1, 1, 10);
    add(0, 3, 0, 1, 0, 1, 1, 1, 10);
    add(1, 10, 0, 1, 0, 1, 1, 1, 11);
    add(0, 0, 0, 1, 0, 1, 1, 1, 11);
    add(1, 11, 0, 1, 0, 1, 1, 1, 12);
    add(1, 5, 0, 0, 1, 1, 2, 1, 6);
    add(1, 6, 0, 0, 0, 1, 2, 1, 7);
    add(1, 7, 0, 1, 0, 1, 2, 1, 8);
    add(1, 0, 0, 0, 1, 1, 3, 1, 1);
    add(1, 1, 0, 0, 0, 1, 3, 1, 2);
    add(1, 2, 0, 1, 0, 1, 3, 1, 3);
    add(1, 9, 0, 0, 1, 1, 3, 1, 10);
    add(1, 10, 0, 0, 0, 1, 3, 1, 11);
    add(1, 11, 0, 1, 0, 1, 3, 1, 12);
    add(1, 0, 0, 0, 1, 1, 3, 1, 1);
    add(1, 1, 0, 0, 0, 1, 3, 1, 2);
    add(1, 2, 0, 1, 0, 1, 3, 1, 3);
    add(0, 7, 1, 1, 0, 0, 0, 0, 3);
    add(1, 9, 1, 0, 1, 1, 1, 0, 10);
    add(1, 10, 0, 0, 0, 1, 1, 0, 11);
    add(1, 11, 0, 1, 0, 1, 1, 0, 12);
    for (int c = 12; c < 16; c++) add(1, c, 0, 1, 0, 1, 1, 0, c + 1);
    add(1, 0, 1, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 1, 0, 0, 0, 1, 2);
    add(1, 1, 0, 0, 1, 1, 1, 1, 2);
    add(1, 2, 0, 0, 0, 1, 1, 1, 3);
    add(1, 3, 0, 1, 0, 1, 1, 1, 4);

    do_reset(2);
    check("reset_state", dut_word(), '0);
    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].cnt, vecs[i].clr);
      check($sformatf("vec[%0d]", i), dut_word(),
            pack(vecs[i].locked, vecs[i].mismatch, vecs[i].sticky,
                 vecs[i].err, vecs[i].wrap, vecs[i].expd));
    end

    // reset while locked with statistics set
    reset = 1'b0;
    drive(1, 4'd4, 1'b0);
    check("reset_mid_locked", dut_word(), '0);
    reset = 1'b1;
    // first sample after reset is never an error; acquire-phase breaks are silent
    drive(1, 4'd9, 1'b0);  check("post_reset_first", dut_word(), pack(0, 0, 0, 0, 0, 10));
    drive(1, 4'd3, 1'b0);  check("acquire_break",    dut_word(), pack(0, 0, 0, 0, 0, 4));
    drive(1, 4'd4, 1'b0);  check("acquire_run1",     dut_word(), pack(0, 0, 0, 0, 0, 5));
    drive(1, 4'd5, 1'b0);  check("acquire_lock",     dut_word(), pack(1, 0, 0, 0, 0, 6));

    // random traffic against the model, through the expected queue
    do_reset(1);
    for (int n = 0; n < 600; n++) begin
      bit v, clr;
      int c;
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      c   = ($urandom_range(0, 9) < 8) ? (m_prev + 1) % MODV : $urandom_range(0, MODV - 1);
      model_step(v, c, clr);
      exp_q.push_back(model_word());
      drive(v, WIDTH'(c), clr);
      check($sformatf("rand[%0d]", n), dut_word(), exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
